// File: rtl/frame_buffer_pkg.sv
// frame_buffer_pkg: shared state encoding and default geometry for the frame buffer pixel writer.
package frame_buffer_pkg;
  localparam int DEF_PIXEL_BITS = 4;
  localparam int DEF_WORD_BITS  = 16;
  typedef enum logic [2:0] {EMPTY, READ, WAIT, HOLD, WRITE} state_e;
endpackage

// File: rtl/pixel_lane_insert.sv
// pixel_lane_insert: replaces one pixel lane of a packed word, leaving the other lanes intact.
module pixel_lane_insert #(
  parameter int PIXEL_BITS = 4,
  parameter int WORD_BITS  = 16,
  localparam int LANES     = WORD_BITS / PIXEL_BITS,
  localparam int LANE_BITS = $clog2(LANES)
) (
  input  logic [WORD_BITS-1:0]  word,
  input  logic [LANE_BITS-1:0]  lane,
  input  logic [PIXEL_BITS-1:0] pixel,
  output logic [WORD_BITS-1:0]  merged
);
  always_comb begin
    merged = word;
    for (int i = 0; i < LANES; i++)
      if (lane == LANE_BITS'(i)) merged[i*PIXEL_BITS +: PIXEL_BITS] = pixel;
  end
endmodule

// File: rtl/frame_buffer_pixel_writer.sv
// frame_buffer_pixel_writer: read-modify-write pixel writer with a one-word coalescing line buffer.
module frame_buffer_pixel_writer
  import frame_buffer_pkg::*;
#(
  parameter int PIXEL_BITS     = DEF_PIXEL_BITS,
  parameter int WORD_BITS      = DEF_WORD_BITS,
  parameter int PIX_ADDR_BITS  = 17,
  parameter int RD_LATENCY     = 1,
  localparam int LANES          = WORD_BITS / PIXEL_BITS,
  localparam int LANE_BITS      = $clog2(LANES),
  localparam int WORD_ADDR_BITS = PIX_ADDR_BITS - LANE_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [PIX_ADDR_BITS-1:0]  pix_addr,
  input  logic [PIXEL_BITS-1:0]     pix_data,
  input  logic                      flush,
  output logic                      idle,
  output logic                      mem_rd_en,
  output logic [WORD_ADDR_BITS-1:0] mem_rd_addr,
  input  logic [WORD_BITS-1:0]      mem_rd_data,
  output logic                      mem_wr_en,
  output logic [WORD_ADDR_BITS-1:0] mem_wr_addr,
  output logic [WORD_BITS-1:0]      mem_wr_data
);
  localparam int CNT_BITS = $clog2(RD_LATENCY + 1);
  state_e                    state_q, state_d;
  logic [WORD_ADDR_BITS-1:0] pend_word_q, pend_word_d, buf_addr_q, buf_addr_d, pix_word;
  logic [LANE_BITS-1:0]      pend_lane_q, pend_lane_d, pix_lane;
  logic [PIXEL_BITS-1:0]     pend_data_q, pend_data_d;
  logic                      pend_v_q, pend_v_d, valid_q, valid_d, dirty_q, dirty_d;
  logic [CNT_BITS-1:0]       cnt_q, cnt_d;
  logic [WORD_BITS-1:0]      buf_q, buf_d, fill_word, hit_word;
  logic                      accept, hit;

  assign pix_word    = pix_addr[PIX_ADDR_BITS-1:LANE_BITS];
  assign pix_lane    = pix_addr[LANE_BITS-1:0];
  assign pix_ready   = (state_q == EMPTY || state_q == HOLD) && !flush;
  assign accept      = pix_valid && pix_ready;
  assign hit         = valid_q && pix_word == buf_addr_q;
  assign idle        = state_q == EMPTY;
  assign mem_rd_en   = state_q == READ;
  assign mem_rd_addr = mem_rd_en ? pend_word_q : '0;
  assign mem_wr_en   = state_q == WRITE;
  assign mem_wr_addr = mem_wr_en ? buf_addr_q : '0;
  assign mem_wr_data = mem_wr_en ? buf_q : '0;

  pixel_lane_insert #(.PIXEL_BITS(PIXEL_BITS), .WORD_BITS(WORD_BITS)) u_fill (
    .word(mem_rd_data), .lane(pend_lane_q), .pixel(pend_data_q), .merged(fill_word)
  );
  pixel_lane_insert #(.PIXEL_BITS(PIXEL_BITS), .WORD_BITS(WORD_BITS)) u_hit (
    .word(buf_q), .lane(pix_lane), .pixel(pix_data), .merged(hit_word)
  );

  always_comb begin
    state_d     = state_q;
    pend_word_d = pend_word_q;
    pend_lane_d = pend_lane_q;
    pend_data_d = pend_data_q;
    pend_v_d    = pend_v_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    buf_addr_d  = buf_addr_q;
    if (accept && !(state_q == HOLD && hit)) begin
      pend_word_d = pix_word;
      pend_lane_d = pix_lane;
      pend_data_d = pix_data;
      pend_v_d    = 1'b1;
    end
    unique case (state_q)
      EMPTY: state_d = accept ? READ : EMPTY;
      READ: begin
        cnt_d   = CNT_BITS'(RD_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_BITS'(1)) begin
          buf_d      = fill_word;
          buf_addr_d = pend_word_q;
          valid_d    = 1'b1;
          dirty_d    = 1'b1;
          pend_v_d   = 1'b0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (accept && hit) begin
          buf_d   = hit_word;
          dirty_d = 1'b1;
        end else if (accept) begin
          state_d = dirty_q ? WRITE : READ;
        end else if (flush) begin
          state_d = dirty_q ? WRITE : EMPTY;
          valid_d = dirty_q;
        end
      end
      WRITE: begin
        dirty_d = 1'b0;
        valid_d = pend_v_q;
        state_d = pend_v_q ? READ : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Reset drops any in-flight read and any dirty word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      pend_word_q <= '0;
      pend_lane_q <= '0;
      pend_data_q <= '0;
      pend_v_q    <= 1'b0;
      valid_q     <= 1'b0;
      dirty_q     <= 1'b0;
      cnt_q       <= '0;
      buf_q       <= '0;
      buf_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_word_q <= pend_word_d;
      pend_lane_q <= pend_lane_d;
      pend_data_q <= pend_data_d;
      pend_v_q    <= pend_v_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      buf_addr_q  <= buf_addr_d;
    end
  end
endmodule

// File: tb/tb_frame_buffer_pixel_writer.sv
// tb_frame_buffer_pixel_writer: directed plus random pixel writes checked against a pixel-level RAM image.
module tb_frame_buffer_pixel_writer;
  localparam int L = 3;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic        pix_valid = 0, flush = 0, pix_ready, idle, mem_rd_en, mem_wr_en;
  logic [16:0] pix_addr = 0;
  logic [3:0]  pix_data = 0;
  logic [14:0] mem_rd_addr, mem_wr_addr;
  logic [15:0] mem_rd_data, mem_wr_data;

  frame_buffer_pixel_writer #(.RD_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_addr(pix_addr), .pix_data(pix_data), .flush(flush), .idle(idle),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  logic        w_valid = 0, w_flush = 0, w_ready, w_idle, w_rd_en, w_wr_en, w_rd_v = 0;
  logic [16:0] w_addr = 0;
  logic [7:0]  w_data = 0;
  logic [14:0] w_rd_addr, w_wr_addr;
  logic [31:0] w_rd_data, w_wr_data, w_last = 0;
  int          w_wr_n = 0;

  frame_buffer_pixel_writer #(.PIXEL_BITS(8), .WORD_BITS(32), .RD_LATENCY(1)) dut_wide (
    .clk(clk), .rst_n(rst_n), .pix_valid(w_valid), .pix_ready(w_ready),
    .pix_addr(w_addr), .pix_data(w_data), .flush(w_flush), .idle(w_idle),
    .mem_rd_en(w_rd_en), .mem_rd_addr(w_rd_addr), .mem_rd_data(w_rd_data),
    .mem_wr_en(w_wr_en), .mem_wr_addr(w_wr_addr), .mem_wr_data(w_wr_data)
  );
  assign w_rd_data = w_rd_v ? 32'h0 : 32'hFFFF_FFFF;
  always @(posedge clk) begin
    w_rd_v <= w_rd_en;
    if (w_wr_en) begin
      w_wr_n <= w_wr_n + 1;
      w_last <= w_wr_data;
    end
  end

  // RAM model: read data is only meaningful exactly L cycles after the strobe.
  logic [15:0] mem [0:32767];
  logic [15:0] ref_word [0:32767];
  logic [15:0] rd_pipe [L];
  logic [L-1:0] rd_vpipe = '0;
  assign mem_rd_data = rd_vpipe[L-1] ? rd_pipe[L-1] : 16'hDEAD;

  typedef struct {bit wr; int addr; int data; int cyc;} ev_t;
  ev_t log_q[$];
  int cyc = 0, viol = 0, checks = 0, errors = 0, acc_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_pipe[0] <= mem[mem_rd_addr];
    for (int k = L - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_vpipe <= {rd_vpipe[L-2:0], mem_rd_en};
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) log_q.push_back('{1'b0, int'(mem_rd_addr), 0, cyc});
    if (mem_wr_en) log_q.push_back('{1'b1, int'(mem_wr_addr), int'(mem_wr_data), cyc});
    if ((mem_rd_en && mem_wr_en) || (mem_rd_en && |rd_vpipe)) viol <= viol + 1;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put(logic [16:0] a, logic [3:0] d);
    bit ok = 0;
    @(negedge clk);
    pix_valid = 1; pix_addr = a; pix_data = d;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (pix_ready) begin
        @(posedge clk);
        ok = 1;
        acc_cyc = cyc;
        ref_word[a[16:2]][a[1:0]*4 +: 4] = d;
      end else @(negedge clk);
    end
    if (!ok) check("put_timeout", 0, 1);
  endtask

  task automatic drop();
    @(negedge clk);
    pix_valid = 0;
  endtask

  task automatic do_flush();
    bit ok = 0;
    @(negedge clk);
    flush = 1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (idle) ok = 1;
    end
    flush = 0;
    if (!ok) check("flush_timeout", 0, 1);
  endtask

  initial begin
    int c1, c3;
    logic [15:0] saved;
    bit ok;
    for (int w = 0; w < 32768; w++) begin
      mem[w] = 16'($urandom);
      ref_word[w] = mem[w];
    end
    mem[1] = 16'h1234; ref_word[1] = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_idle", idle, 1);
    check("rst_ready", pix_ready, 1);
    check("rst_strobes", {mem_rd_en, mem_wr_en}, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_outs", {mem_rd_addr, mem_wr_addr, mem_wr_data}, 0);

    put(17'h4, 4'hA); drop(); repeat (8) @(negedge clk);
    check("t1_ops", log_q.size(), 1);
    check("t1_rd", {log_q[0].wr, log_q[0].addr[14:0]}, {1'b0, 15'd1});
    log_q.delete();
    do_flush();
    check("t1_wb_ops", log_q.size(), 1);
    check("t1_wb", {log_q[0].wr, log_q[0].addr[14:0], log_q[0].data[15:0]}, {1'b1, 15'd1, 16'h123A});

    put(17'h4, 4'hA); drop(); repeat (8) @(negedge clk);
    log_q.delete();
    put(17'h5, 4'h5); c1 = acc_cyc;
    put(17'h6, 4'h6);
    put(17'h7, 4'h7); c3 = acc_cyc;
    drop();
    check("hit_rate", c3 - c1, 2);
    check("hit_quiet", log_q.size(), 0);
    do_flush();
    check("hit_wb_ops", log_q.size(), 1);
    check("hit_wb", log_q[0].data, 32'h765A);

    put(17'h4, 4'hB); drop(); repeat (8) @(negedge clk);
    log_q.delete();
    put(17'h20, 4'hC); c1 = acc_cyc; drop(); repeat (10) @(negedge clk);
    check("miss_ops", log_q.size(), 2);
    check("miss_wr", {log_q[0].wr, log_q[0].addr[14:0], log_q[0].data[15:0]}, {1'b1, 15'd1, 16'h765B});
    check("miss_wr_cyc", log_q[0].cyc, c1 + 1);
    check("miss_rd", {log_q[1].wr, log_q[1].addr[14:0]}, {1'b0, 15'd8});
    check("miss_rd_cyc", log_q[1].cyc, c1 + 2);

    log_q.delete();
    @(negedge clk);
    pix_valid = 1; pix_addr = 17'h24; pix_data = 4'h3; flush = 1;
    #1 check("flush_beats_valid", pix_ready, 0);
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (idle) ok = 1;
    end
    check("flush_idle", idle, 1);
    check("flush_wb", {log_q[0].wr, log_q[0].addr[14:0], log_q[0].data[15:0]}, {1'b1, 15'd8, ref_word[8]});
    flush = 0;
    put(17'h24, 4'h3); drop(); do_flush();
    check("after_flush", {log_q[$].wr, log_q[$].addr[14:0], log_q[$].data[15:0]}, {1'b1, 15'd9, ref_word[9]});

    log_q.delete();
    saved = ref_word[16];
    put(17'h40, 4'h1); drop(); @(negedge clk);
    rst_n = 0;
    #1;
    check("arst_idle", idle, 1);
    check("arst_ready", pix_ready, 1);
    check("arst_outs", {mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_data}, 0);
    ref_word[16] = saved;
    @(negedge clk); rst_n = 1;
    repeat (6) @(negedge clk);
    do_flush();
    check("late_data_ignored", log_q.size(), 1);
    put(17'h40, 4'h2); drop(); do_flush();
    check("arst_refill", {log_q[$].wr, log_q[$].addr[14:0], log_q[$].data[15:0]}, {1'b1, 15'd16, ref_word[16]});

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      else begin
        put(17'($urandom_range(0, 63)), 4'($urandom));
        if ($urandom_range(0, 3) == 0) drop();
      end
    end
    drop(); do_flush();
    for (int w = 0; w < 16; w++) check($sformatf("rand_word%0d", w), mem[w], ref_word[w]);
    check("rd_wr_protocol", viol, 0);

    @(negedge clk);
    w_valid = 1; w_addr = 17'd3; w_data = 8'hFF;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (w_ready) begin
        @(posedge clk);
        ok = 1;
      end else @(negedge clk);
    end
    @(negedge clk);
    w_valid = 0; w_flush = 1;
    ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      if (w_idle) ok = 1;
    end
    w_flush = 0;
    check("wide_idle", w_idle, 1);
    check("wide_wr_count", w_wr_n, 1);
    check("wide_wr_data", w_last, 32'hFF00_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
